// File: rtl/bitcount_accum.sv
// Accumulates a burst of per-word ones-counts into a saturating running total.
// Optional BITCOUNT_ACCUM_MAX_EN adds a max_count output tracking the largest count seen.
//
// state | meaning
// IDLE  | waiting for start; outputs hold the last burst's result
// RUN   | accepting in_count words until remaining reaches zero
// DONE  | one-cycle completion pulse, then back to IDLE
module bitcount_accum #(
    parameter int CNT_W = 6,
    parameter int ACC_W = 16,
    parameter int LEN_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             in_valid,
    input  logic [CNT_W-1:0] in_count,
    output logic             in_ready,
    output logic             busy,
    output logic             done,
    output logic [ACC_W-1:0] total,
    output logic             sat,
`ifdef BITCOUNT_ACCUM_MAX_EN
    output logic [CNT_W-1:0] max_count,
`endif
    output logic [LEN_W-1:0] words
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    state_t           state_nx;
    logic [LEN_W-1:0] remaining;
    logic             start_ok;
    logic             xfer;
    logic [ACC_W:0]   cnt_ext;
    logic [ACC_W:0]   sum;

    assign start_ok = (state == IDLE) && start;
    assign xfer     = (state == RUN) && in_valid;
    assign cnt_ext  = (ACC_W+1)'(in_count);
    assign sum      = {1'b0, total} + cnt_ext;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (start) state_nx = (len == '0) ? DONE : RUN;
            RUN:  if (xfer && remaining == LEN_W'(1)) state_nx = DONE;
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state == RUN);
        busy     = (state != IDLE);
        done     = (state == DONE);
    end

    // A carry out of the sum means the total no longer fits; clip and flag it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            remaining <= '0;
            total     <= '0;
            sat       <= 1'b0;
            words     <= '0;
        end else if (start_ok) begin
            remaining <= len;
            total     <= '0;
            sat       <= 1'b0;
            words     <= '0;
        end else if (xfer) begin
            remaining <= remaining - 1'b1;
            words     <= words + 1'b1;
            if (sum[ACC_W]) begin
                total <= '1;
                sat   <= 1'b1;
            end else begin
                total <= sum[ACC_W-1:0];
            end
        end
    end

`ifdef BITCOUNT_ACCUM_MAX_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                           max_count <= '0;
        else if (start_ok)                    max_count <= '0;
        else if (xfer && in_count > max_count) max_count <= in_count;
    end
`endif

endmodule

// File: tb/tb_bitcount_accum.sv
// Directed bench for bitcount_accum: two instances (16-bit and 8-bit totals) share stimulus.
module tb_bitcount_accum;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [4:0] len;
    logic       in_valid;
    logic [5:0] in_count;

    logic        in_ready16, busy16, done16, sat16;
    logic [15:0] total16;
    logic [4:0]  words16;
    logic        in_ready8, busy8, done8, sat8;
    logic [7:0]  total8;
    logic [4:0]  words8;
`ifdef BITCOUNT_ACCUM_MAX_EN
    logic [5:0]  max16, max8;
`endif

    int checks = 0;
    int failures = 0;
    int done_seen = 0;

    always #5 clk = ~clk;

    bitcount_accum #(.CNT_W(6), .ACC_W(16), .LEN_W(5)) dut16 (
        .clk(clk), .reset(reset), .start(start), .len(len),
        .in_valid(in_valid), .in_count(in_count), .in_ready(in_ready16),
        .busy(busy16), .done(done16), .total(total16), .sat(sat16),
`ifdef BITCOUNT_ACCUM_MAX_EN
        .max_count(max16),
`endif
        .words(words16));

    bitcount_accum #(.CNT_W(6), .ACC_W(8), .LEN_W(5)) dut8 (
        .clk(clk), .reset(reset), .start(start), .len(len),
        .in_valid(in_valid), .in_count(in_count), .in_ready(in_ready8),
        .busy(busy8), .done(done8), .total(total8), .sat(sat8),
`ifdef BITCOUNT_ACCUM_MAX_EN
        .max_count(max8),
`endif
        .words(words8));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (done16) done_seen++;
    endtask

    initial begin
        int cnt4[4];
        int cnt3[3];
        reset = 1'b0; start = 1'b0; len = '0; in_valid = 1'b0; in_count = '0;
        #2;
        check("rst_ready", {31'd0, in_ready16}, 0);
        check("rst_busy",  {31'd0, busy16}, 0);
        check("rst_done",  {31'd0, done16}, 0);
        check("rst_total", {16'd0, total16}, 0);
        check("rst_sat",   {31'd0, sat16}, 0);
        check("rst_words", {27'd0, words16}, 0);
`ifdef BITCOUNT_ACCUM_MAX_EN
        check("rst_max",   {26'd0, max16}, 0);
`endif
        step();
        reset = 1'b1;
        step();

        // reset mid-burst
        start = 1'b1; len = 5'd4;
        step();
        start = 1'b0; in_valid = 1'b1; in_count = 6'd32;
        step();
        step();
        in_valid = 1'b0;
        check("mid_total_pre", {16'd0, total16}, 64);
        check("mid_words_pre", {27'd0, words16}, 2);
        reset = 1'b0;
        #1;
        check("mid_total", {16'd0, total16}, 0);
        check("mid_words", {27'd0, words16}, 0);
        check("mid_ready", {31'd0, in_ready16}, 0);
        check("mid_busy",  {31'd0, busy16}, 0);
        reset = 1'b1;
        step();

        // nominal burst
        cnt4 = '{32, 31, 31, 30};
        start = 1'b1; len = 5'd4;
        step();
        start = 1'b0; in_valid = 1'b1;
        foreach (cnt4[i]) begin
            in_count = 6'(cnt4[i]);
            check("nom_ready", {31'd0, in_ready16}, 1);
            step();
        end
        in_valid = 1'b0;
        check("nom_done",   {31'd0, done16}, 1);
        check("nom_ready_done", {31'd0, in_ready16}, 0);
        check("nom_total",  {16'd0, total16}, 124);
        check("nom_total8", {24'd0, total8}, 124);
        check("nom_words",  {27'd0, words16}, 4);
        check("nom_sat",    {31'd0, sat16}, 0);
        step();
        check("nom_done_off", {31'd0, done16}, 0);
        check("nom_hold",     {16'd0, total16}, 124);

        // stalls with a stray start mid-burst
        cnt3 = '{5, 0, 7};
        start = 1'b1; len = 5'd3;
        step();
        start = 1'b0;
        done_seen = 0;
        foreach (cnt3[i]) begin
            in_valid = 1'b0;
            start = (i == 1);
            len = 5'd9;
            step();
            start = 1'b0;
            step();
            in_valid = 1'b1; in_count = 6'(cnt3[i]);
            step();
        end
        in_valid = 1'b0;
        check("stall_total", {16'd0, total16}, 12);
        check("stall_words", {27'd0, words16}, 3);
        step();
        step();
        check("stall_done_once", done_seen, 1);
        check("stall_idle", {31'd0, busy16}, 0);

        // len==0, start held through DONE
        start = 1'b1; len = 5'd0;
        step();
        check("len0_done",  {31'd0, done16}, 1);
        check("len0_ready", {31'd0, in_ready16}, 0);
        check("len0_total", {16'd0, total16}, 0);
        len = 5'd1;
        step();
        check("len0_idle", {31'd0, busy16}, 0);
        check("len0_doff", {31'd0, done16}, 0);
        step();
        start = 1'b0;
        check("len0_next_run", {31'd0, in_ready16}, 1);
        in_valid = 1'b1; in_count = 6'd9;
        step();
        in_valid = 1'b0;
        check("len0_next_total", {16'd0, total16}, 9);
        check("len0_next_done",  {31'd0, done16}, 1);
        step();

        // saturation on the 8-bit instance
        start = 1'b1; len = 5'd9;
        step();
        start = 1'b0; in_valid = 1'b1; in_count = 6'd32;
        for (int k = 1; k <= 9; k++) begin
            step();
            if (k == 7) begin
                check("sat_w7_total", {24'd0, total8}, 224);
                check("sat_w7_sat",   {31'd0, sat8}, 0);
            end
            if (k == 8) begin
                check("sat_w8_total", {24'd0, total8}, 255);
                check("sat_w8_sat",   {31'd0, sat8}, 1);
            end
        end
        in_valid = 1'b0;
        check("sat_done",    {31'd0, done8}, 1);
        check("sat_total",   {24'd0, total8}, 255);
        check("sat_flag",    {31'd0, sat8}, 1);
        check("sat_words",   {27'd0, words8}, 9);
        check("sat_total16", {16'd0, total16}, 288);
        check("sat_flag16",  {31'd0, sat16}, 0);
        step();
        start = 1'b1; len = 5'd1;
        step();
        start = 1'b0; in_valid = 1'b1; in_count = 6'd3;
        step();
        in_valid = 1'b0;
        check("sat_next_total", {24'd0, total8}, 3);
        check("sat_next_sat",   {31'd0, sat8}, 0);
        step();

`ifdef BITCOUNT_ACCUM_MAX_EN
        cnt3 = '{3, 32, 17};
        start = 1'b1; len = 5'd3;
        step();
        start = 1'b0; in_valid = 1'b1;
        foreach (cnt3[i]) begin
            in_count = 6'(cnt3[i]);
            step();
        end
        in_valid = 1'b0;
        step();
        check("max_after_done", {26'd0, max16}, 32);
        check("max_after_done8", {26'd0, max8}, 32);
        reset = 1'b0;
        #1;
        check("max_after_reset", {26'd0, max16}, 0);
        reset = 1'b1;
        step();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
